bch_dec_err_monitor: RTL and testbench

- Self-checking result monitor for the n-parallel SD-BCH decoder bench. It replaces the ad-hoc XOR error wire and the fixed clock-cycle counter with one block.
- Aligns decoder output beats to expected codeword beats and counts bit errors per codeword, plus accumulated bit errors and frame errors.
- Checks that each codeword spans exactly ceil(CW_LEN/PARALLELISM) enabled beats, with a mask for a partial last beat.
- Sits between the decoder outputs (out_codeword, out_out_start), the verify-vector loader and the bench status outputs.

---
 rtl/bch_dec_err_monitor_if.sv | 38 +++
 rtl/bch_dec_err_monitor.sv | 138 +++++++++++++
 tb/tb_bch_dec_err_monitor.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bch_dec_err_monitor_if.sv
// Beat and result bundle between the decoder bench and the error monitor.
// The master drives decoder beats and expected bits; the slave reports results.
interface bch_dec_err_monitor_if #(
    parameter int PARALLELISM = 4,
    parameter int WERR_LEN    = 10,
    parameter int BERR_LEN    = 32,
    parameter int FERR_LEN    = 16,
    parameter int BEAT_LEN    = 10
);
    logic                   in_en;
    logic                   in_clear;
    logic                   in_start;
    logic [PARALLELISM-1:0] in_codeword;
    logic [PARALLELISM-1:0] in_expect;
    logic                   out_word_done;
    logic [WERR_LEN-1:0]    out_word_err;
    logic                   out_word_fail;
    logic [BERR_LEN-1:0]    out_total_bit_err;
    logic [FERR_LEN-1:0]    out_total_frame_err;
    logic [FERR_LEN-1:0]    out_word_cnt;
    logic [BEAT_LEN-1:0]    out_beat_cnt;
    logic                   out_len_err;
    logic                   out_all_done;

    modport master (
        output in_en, in_clear, in_start, in_codeword, in_expect,
        input  out_word_done, out_word_err, out_word_fail,
        input  out_total_bit_err, out_total_frame_err, out_word_cnt,
        input  out_beat_cnt, out_len_err, out_all_done
    );

    modport slave (
        input  in_en, in_clear, in_start, in_codeword, in_expect,
        output out_word_done, out_word_err, out_word_fail,
        output out_total_bit_err, out_total_frame_err, out_word_cnt,
        output out_beat_cnt, out_len_err, out_all_done
    );
endinterface

// File: rtl/bch_dec_err_monitor.sv
// Aligns decoder beats to expected beats, counts per-word and total errors,
// checks codeword framing and stops once WORD_NUM words have been seen.
module bch_dec_err_monitor #(
    parameter int PARALLELISM = 4,
    parameter int CW_LEN      = 1020,
    parameter int WORD_NUM    = 100,
    parameter int WERR_LEN    = 10,
    parameter int BERR_LEN    = 32,
    parameter int FERR_LEN    = 16,
    parameter int BEAT_LEN    = 10
) (
    input logic                  clk,
    input logic                  in_Arst_n,
    bch_dec_err_monitor_if.slave mon
);
    localparam int BEATS = (CW_LEN + PARALLELISM - 1) / PARALLELISM;
    localparam int REM   = CW_LEN - (BEATS - 1) * PARALLELISM;

    typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

    state_t                 state;
    logic [WERR_LEN-1:0]    acc;
    logic [WERR_LEN-1:0]    bit_cnt;
    logic [WERR_LEN-1:0]    word_sum;
    logic [PARALLELISM-1:0] mask;
    logic [PARALLELISM-1:0] diff;
    logic                   fresh;
    logic                   last;
    logic [BERR_LEN:0]      bit_sum;
    logic [BERR_LEN-1:0]    tot_bit;
    logic [BERR_LEN-1:0]    tot_bit_nx;
    logic [FERR_LEN-1:0]    tot_fe;
    logic [FERR_LEN-1:0]    tot_fe_nx;
    logic [FERR_LEN-1:0]    wcnt;
    logic [FERR_LEN-1:0]    wcnt_nx;
    logic [BEAT_LEN-1:0]    beat_cnt;
    logic                   word_done;
    logic [WERR_LEN-1:0]    word_err;
    logic                   word_fail;
    logic                   len_err;
    logic                   all_done;

    // A start beat is always beat 0, whether from IDLE or a restart in RUN.
    always_comb begin
        fresh = mon.in_start || (state == IDLE);
        last  = fresh ? (BEATS == 1)
                      : (beat_cnt == BEAT_LEN'(BEATS - 1));
        for (int i = 0; i < PARALLELISM; i++) begin
            mask[i] = !last || (i < REM);
        end
        diff    = (mon.in_codeword ^ mon.in_expect) & mask;
        bit_cnt = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            bit_cnt = bit_cnt + WERR_LEN'(diff[i]);
        end
        word_sum   = (fresh ? '0 : acc) + bit_cnt;
        bit_sum    = {1'b0, tot_bit} + (BERR_LEN + 1)'(word_sum);
        tot_bit_nx = bit_sum[BERR_LEN] ? '1 : bit_sum[BERR_LEN-1:0];
        tot_fe_nx  = (word_sum != '0 && tot_fe != '1)
                   ? tot_fe + FERR_LEN'(1) : tot_fe;
        wcnt_nx    = (wcnt != '1) ? wcnt + FERR_LEN'(1) : wcnt;
    end

    always_ff @(posedge clk or negedge in_Arst_n) begin
        if (!in_Arst_n) begin
            state     <= IDLE;
            acc       <= '0;
            tot_bit   <= '0;
            tot_fe    <= '0;
            wcnt      <= '0;
            beat_cnt  <= '0;
            word_done <= 1'b0;
            word_err  <= '0;
            word_fail <= 1'b0;
            len_err   <= 1'b0;
            all_done  <= 1'b0;
        end else if (mon.in_clear) begin
            state     <= IDLE;
            acc       <= '0;
            tot_bit   <= '0;
            tot_fe    <= '0;
            wcnt      <= '0;
            beat_cnt  <= '0;
            word_done <= 1'b0;
            word_err  <= '0;
            word_fail <= 1'b0;
            len_err   <= 1'b0;
            all_done  <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (mon.in_en) begin
                unique case (state)
                    IDLE, RUN: begin
                        if (state == RUN || mon.in_start) begin
                            if (state == RUN && mon.in_start) begin
                                len_err <= 1'b1;
                            end
                            if (last) begin
                                word_done <= 1'b1;
                                word_err  <= word_sum;
                                word_fail <= (word_sum != '0);
                                tot_bit   <= tot_bit_nx;
                                tot_fe    <= tot_fe_nx;
                                wcnt      <= wcnt_nx;
                                acc       <= '0;
                                beat_cnt  <= '0;
                                if (wcnt_nx == FERR_LEN'(WORD_NUM)) begin
                                    all_done <= 1'b1;
                                    state    <= FULL;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                acc      <= word_sum;
                                beat_cnt <= fresh ? BEAT_LEN'(1)
                                                  : beat_cnt + BEAT_LEN'(1);
                                state    <= RUN;
                            end
                        end
                    end
                    FULL: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign mon.out_word_done       = word_done;
    assign mon.out_word_err        = word_err;
    assign mon.out_word_fail       = word_fail;
    assign mon.out_total_bit_err   = tot_bit;
    assign mon.out_total_frame_err = tot_fe;
    assign mon.out_word_cnt        = wcnt;
    assign mon.out_beat_cnt        = beat_cnt;
    assign mon.out_len_err         = len_err;
    assign mon.out_all_done        = all_done;
endmodule

// File: tb/tb_bch_dec_err_monitor.sv
// Bench for bch_dec_err_monitor: two instances (1020-bit, 3 words; 1022-bit)
// checked against a word-level reference model plus directed vectors.
module tb_bch_dec_err_monitor;
    localparam int P = 4;

    typedef struct {
        int     busy;
        int     full;
        int     pos;
        int     acc;
        int     done;
        int     werr;
        int     fail;
        longint tbe;
        int     tfe;
        int     wc;
        int     len_err;
        int     all;
    } mdl_t;

    typedef struct {
        bit       use_b;
        bit       tog;
        int       b0;
        int       b1;
        int       b2;
        logic [3:0] m0;
        logic [3:0] m1;
        logic [3:0] m2;
        int       exp_err;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         clr = 1'b0;
    logic         sta = 1'b0;
    logic         stb = 1'b0;
    logic [P-1:0] cw = '0;
    logic [P-1:0] ex = '0;
    int           n_chk = 0;
    int           n_fail = 0;
    mdl_t         ma;
    mdl_t         mb;

    always #5 clk = ~clk;

    bch_dec_err_monitor_if #(.PARALLELISM(P)) ifa ();
    bch_dec_err_monitor_if #(.PARALLELISM(P)) ifb ();

    assign ifa.in_en       = en;
    assign ifa.in_clear    = clr;
    assign ifa.in_start    = sta;
    assign ifa.in_codeword = cw;
    assign ifa.in_expect   = ex;
    assign ifb.in_en       = en;
    assign ifb.in_clear    = clr;
    assign ifb.in_start    = stb;
    assign ifb.in_codeword = cw;
    assign ifb.in_expect   = ex;

    bch_dec_err_monitor #(
        .PARALLELISM(P), .CW_LEN(1020), .WORD_NUM(3)
    ) ua (
        .clk(clk), .in_Arst_n(rst_n), .mon(ifa.slave)
    );

    bch_dec_err_monitor #(
        .PARALLELISM(P), .CW_LEN(1022), .WORD_NUM(100)
    ) ub (
        .clk(clk), .in_Arst_n(rst_n), .mon(ifb.slave)
    );

    // Word-level model: position within the word, running error sum, counters.
    function automatic mdl_t mstep(mdl_t m, int beats, int rem, int wnum,
                                   logic e, logic c, logic s,
                                   logic [P-1:0] d, logic [P-1:0] x);
        mdl_t n;
        int   errs;
        n = m;
        n.done = 0;
        if (c) begin
            n = '{default: 0};
            return n;
        end
        if (!e || n.full != 0) return n;
        if (n.busy != 0 && s) n.len_err = 1;
        if (s) begin
            n.busy = 1;
            n.pos  = 0;
            n.acc  = 0;
        end
        if (n.busy == 0) return n;
        errs = 0;
        for (int i = 0; i < P; i++) begin
            if ((n.pos < beats - 1 || i < rem) && (d[i] != x[i])) errs++;
        end
        n.acc = n.acc + errs;
        n.pos = n.pos + 1;
        if (n.pos == beats) begin
            n.busy = 0;
            n.pos  = 0;
            n.done = 1;
            n.werr = n.acc;
            n.fail = (n.acc != 0) ? 1 : 0;
            n.tbe  = n.tbe + n.acc;
            if (n.tbe > 64'hFFFF_FFFF) n.tbe = 64'hFFFF_FFFF;
            if (n.fail != 0 && n.tfe < 65535) n.tfe++;
            if (n.wc < 65535) n.wc++;
            if (n.wc == wnum) begin
                n.all  = 1;
                n.full = 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '{default: 0};
            mb <= '{default: 0};
        end else begin
            ma <= mstep(ma, 255, 4, 3, en, clr, sta, cw, ex);
            mb <= mstep(mb, 256, 2, 100, en, clr, stb, cw, ex);
        end
    end

    task automatic chk(string nm, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic mcheck(string nm, mdl_t m, logic d, logic [9:0] we,
                          logic f, logic [31:0] tb, logic [15:0] tf,
                          logic [15:0] wc, logic [9:0] bc, logic le,
                          logic ad);
        n_chk++;
        if ({d, we, f, tb, tf, wc, bc, le, ad} !==
            {1'(m.done), 10'(m.werr), 1'(m.fail), 32'(m.tbe),
             16'(m.tfe), 16'(m.wc), 10'(m.pos), 1'(m.len_err),
             1'(m.all)}) begin
            n_fail++;
            $display("FAIL %s model: got d=%0d we=%0d f=%0d tb=%0d tf=%0d wc=%0d bc=%0d le=%0d ad=%0d exp d=%0d we=%0d f=%0d tb=%0d tf=%0d wc=%0d bc=%0d le=%0d ad=%0d",
                     nm, d, we, f, tb, tf, wc, bc, le, ad,
                     m.done, m.werr, m.fail, m.tbe, m.tfe, m.wc, m.pos,
                     m.len_err, m.all);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mcheck("dut_a", ma, ifa.out_word_done, ifa.out_word_err,
               ifa.out_word_fail, ifa.out_total_bit_err,
               ifa.out_total_frame_err, ifa.out_word_cnt,
               ifa.out_beat_cnt, ifa.out_len_err, ifa.out_all_done);
        mcheck("dut_b", mb, ifb.out_word_done, ifb.out_word_err,
               ifb.out_word_fail, ifb.out_total_bit_err,
               ifb.out_total_frame_err, ifb.out_word_cnt,
               ifb.out_beat_cnt, ifb.out_len_err, ifb.out_all_done);
    endtask

    task automatic clear_pulse();
        en  = 1'b0;
        sta = 1'b0;
        stb = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic send(vec_t v);
        int         nb;
        logic [3:0] f;
        nb = v.use_b ? 256 : 255;
        for (int b = 0; b < nb; b++) begin
            if (v.tog) begin
                en  = 1'b0;
                sta = 1'b0;
                stb = 1'b0;
                cw  = 4'($urandom);
                ex  = 4'($urandom);
                tick();
            end
            en  = 1'b1;
            sta = !v.use_b && (b == 0);
            stb = v.use_b && (b == 0);
            cw  = 4'($urandom);
            f   = (b == v.b0 ? v.m0 : 4'h0) | (b == v.b1 ? v.m1 : 4'h0)
                | (b == v.b2 ? v.m2 : 4'h0);
            ex  = cw ^ f;
            tick();
        end
        en  = 1'b0;
        sta = 1'b0;
        stb = 1'b0;
    endtask

    task automatic beats(bit use_b, int n, bit first_start);
        for (int b = 0; b < n; b++) begin
            en  = 1'b1;
            sta = !use_b && first_start && (b == 0);
            stb = use_b && first_start && (b == 0);
            cw  = 4'($urandom);
            ex  = cw;
            tick();
        end
        en  = 1'b0;
        sta = 1'b0;
        stb = 1'b0;
    endtask

    vec_t vecs[7];
    vec_t v1;

    initial begin
        vecs[0] = '{0, 0, -1, -1, -1, 4'h0, 4'h0, 4'h0, 0};
        vecs[1] = '{0, 0, 0, 100, 254, 4'h4, 4'h4, 4'h4, 3};
        vecs[2] = '{1, 0, 255, -1, -1, 4'hC, 4'h0, 4'h0, 0};
        vecs[3] = '{1, 0, 255, -1, -1, 4'h2, 4'h0, 4'h0, 1};
        vecs[4] = '{0, 0, 10, 254, -1, 4'hF, 4'h9, 4'h0, 6};
        vecs[5] = '{0, 1, 0, 100, 254, 4'h4, 4'h4, 4'h4, 3};
        vecs[6] = '{1, 0, 0, 255, -1, 4'hF, 4'hF, 4'h0, 6};

        #12;
        chk("rst_wcnt", ifa.out_word_cnt, 0);
        chk("rst_done", ifa.out_word_done, 0);
        chk("rst_beat", ifb.out_beat_cnt, 0);
        chk("rst_all", ifa.out_all_done, 0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[k]) begin
            clear_pulse();
            send(vecs[k]);
            if (vecs[k].use_b) begin
                chk("vec_done", ifb.out_word_done, 1);
                chk("vec_werr", ifb.out_word_err, vecs[k].exp_err);
                chk("vec_fail", ifb.out_word_fail, vecs[k].exp_err != 0);
                chk("vec_tbe", ifb.out_total_bit_err, vecs[k].exp_err);
                chk("vec_tfe", ifb.out_total_frame_err,
                    vecs[k].exp_err != 0);
                chk("vec_wc", ifb.out_word_cnt, 1);
            end else begin
                chk("vec_done", ifa.out_word_done, 1);
                chk("vec_werr", ifa.out_word_err, vecs[k].exp_err);
                chk("vec_fail", ifa.out_word_fail, vecs[k].exp_err != 0);
                chk("vec_tbe", ifa.out_total_bit_err, vecs[k].exp_err);
                chk("vec_tfe", ifa.out_total_frame_err,
                    vecs[k].exp_err != 0);
                chk("vec_wc", ifa.out_word_cnt, 1);
            end
            tick();
            chk("vec_pulse_drop", ifa.out_word_done | ifb.out_word_done, 0);
        end

        // Restart at beat 100 discards the partial word.
        clear_pulse();
        beats(0, 100, 1);
        chk("rs_beat", ifa.out_beat_cnt, 100);
        chk("rs_lenerr0", ifa.out_len_err, 0);
        send(vecs[0]);
        chk("rs_lenerr", ifa.out_len_err, 1);
        chk("rs_done", ifa.out_word_done, 1);
        chk("rs_wc", ifa.out_word_cnt, 1);

        // Three back-to-back single-error words fill dut_a.
        clear_pulse();
        v1 = '{0, 0, 7, -1, -1, 4'h1, 4'h0, 4'h0, 1};
        for (int k = 0; k < 3; k++) send(v1);
        chk("full_wc", ifa.out_word_cnt, 3);
        chk("full_all", ifa.out_all_done, 1);
        chk("full_tfe", ifa.out_total_frame_err, 3);
        chk("full_tbe", ifa.out_total_bit_err, 3);
        chk("full_lenerr", ifa.out_len_err, 0);
        send(v1);
        chk("full_ign_wc", ifa.out_word_cnt, 3);
        chk("full_ign_done", ifa.out_word_done, 0);

        // Async reset while dut_b is mid-word and dut_a is full.
        beats(1, 50, 1);
        chk("ar_beat_b", ifb.out_beat_cnt, 50);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_wc", ifa.out_word_cnt, 0);
        chk("ar_all", ifa.out_all_done, 0);
        chk("ar_tbe", ifa.out_total_bit_err, 0);
        chk("ar_beat_b", ifb.out_beat_cnt, 0);
        #1 rst_n = 1'b1;
        tick();

        // Clear mid-word wins over a coincident start beat.
        send(v1);
        beats(0, 30, 1);
        chk("cl_beat", ifa.out_beat_cnt, 30);
        en  = 1'b1;
        sta = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        sta = 1'b0;
        chk("cl_beat0", ifa.out_beat_cnt, 0);
        chk("cl_wc", ifa.out_word_cnt, 0);
        chk("cl_werr", ifa.out_word_err, 0);
        tick();
        chk("cl_idle", ifa.out_beat_cnt, 0);

        for (int c = 0; c < 6000; c++) begin
            en  = ($urandom_range(0, 3) != 0);
            sta = ($urandom_range(0, 399) == 0);
            stb = ($urandom_range(0, 399) == 0);
            clr = ($urandom_range(0, 3999) == 0);
            cw  = 4'($urandom);
            ex  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : cw;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
